// File: rtl/divisor_secuencial.sv
// Sequential signed restoring divider: one shift/trial-subtract step per clock,
// truncated quotient and dividend-signed remainder, with a one-cycle DONE.
module divisor_secuencial #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             init,
   input  logic [WIDTH-1:0] Dividendo,
   input  logic [WIDTH-1:0] Divisor,
   output logic [WIDTH-1:0] Cociente,
   output logic [WIDTH-1:0] Residuo,
   output logic             DONE,
   output logic             BUSY,
   output logic             DIV0,
   output logic             OVF
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ITER,
      S_SIGN,
      S_FIN
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_m;
   logic [WIDTH:0]   r_r;
   logic [CW-1:0]    r_cnt;
   logic             r_sign_q;
   logic             r_sign_r;
   logic [WIDTH-1:0] r_coc;
   logic [WIDTH-1:0] r_res;
   logic             r_done;
   logic             r_busy;
   logic             r_div0;
   logic             r_ovf;

   logic [WIDTH-1:0] w_abs_dvd;
   logic [WIDTH-1:0] w_abs_dvs;
   logic [WIDTH+1:0] w_trial;
   logic             w_fits;
   logic [WIDTH-1:0] w_q_signed;
   logic [WIDTH-1:0] w_r_signed;
   logic [WIDTH-1:0] w_min;
   logic             w_is_ovf;

   // |MIN| wraps to 2^(WIDTH-1), which is exactly right as an unsigned magnitude.
   assign w_abs_dvd  = r_dvd[WIDTH-1] ? -r_dvd : r_dvd;
   assign w_abs_dvs  = r_dvs[WIDTH-1] ? -r_dvs : r_dvs;
   assign w_trial    = {r_r, r_q[WIDTH-1]} - {2'b00, r_m};
   assign w_fits     = ~w_trial[WIDTH+1];
   assign w_q_signed = r_sign_q ? -r_q : r_q;
   assign w_r_signed = r_sign_r ? -r_r[WIDTH-1:0] : r_r[WIDTH-1:0];
   assign w_min      = {1'b1, {(WIDTH-1){1'b0}}};
   assign w_is_ovf   = (r_dvd == w_min) && (r_dvs == '1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_dvd    <= '0;
         r_dvs    <= '0;
         r_q      <= '0;
         r_m      <= '0;
         r_r      <= '0;
         r_cnt    <= '0;
         r_sign_q <= 1'b0;
         r_sign_r <= 1'b0;
         r_coc    <= '0;
         r_res    <= '0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
         r_div0   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (init) begin
                  r_dvd    <= Dividendo;
                  r_dvs    <= Divisor;
                  r_sign_q <= Dividendo[WIDTH-1] ^ Divisor[WIDTH-1];
                  r_sign_r <= Dividendo[WIDTH-1];
                  r_div0   <= 1'b0;
                  r_ovf    <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_q   <= w_abs_dvd;
               r_m   <= w_abs_dvs;
               r_r   <= '0;
               r_cnt <= CW'(WIDTH);
               // A zero divisor skips the iterations; SIGN recognises it by M == 0.
               r_state <= (r_dvs == '0) ? S_SIGN : S_ITER;
            end
            S_ITER: begin
               if (w_fits) begin
                  r_r <= w_trial[WIDTH:0];
               end else begin
                  r_r <= {r_r[WIDTH-1:0], r_q[WIDTH-1]};
               end
               r_q   <= {r_q[WIDTH-2:0], w_fits};
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CW'(1)) begin
                  r_state <= S_SIGN;
               end
            end
            S_SIGN: begin
               if (r_m == '0) begin
                  r_coc  <= '1;
                  r_res  <= r_dvd;
                  r_div0 <= 1'b1;
               end else begin
                  r_coc <= w_q_signed;
                  r_res <= w_r_signed;
                  r_ovf <= w_is_ovf;
               end
               r_done  <= 1'b1;
               r_state <= S_FIN;
            end
            S_FIN: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign Cociente = r_coc;
   assign Residuo  = r_res;
   assign DONE     = r_done;
   assign BUSY     = r_busy;
   assign DIV0     = r_div0;
   assign OVF      = r_ovf;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Directed bench for divisor_secuencial: an arithmetic reference model checked every
// cycle, plus literal expectations per vector.
module tb_divisor_secuencial;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        init = 1'b0;
   logic [15:0] Dividendo = '0;
   logic [15:0] Divisor = '0;
   logic [15:0] Cociente;
   logic [15:0] Residuo;
   logic        DONE;
   logic        BUSY;
   logic        DIV0;
   logic        OVF;

   divisor_secuencial #(.WIDTH(16)) dut (
      .clk      (clk),
      .reset    (reset),
      .init     (init),
      .Dividendo(Dividendo),
      .Divisor  (Divisor),
      .Cociente (Cociente),
      .Residuo  (Residuo),
      .DONE     (DONE),
      .BUSY     (BUSY),
      .DIV0     (DIV0),
      .OVF      (OVF)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   // Expectation of the operation in flight
   bit          pending = 1'b0;
   int          k_edge = 0;
   int          lat = 0;
   logic [15:0] exp_q, exp_r;
   logic        exp_d0, exp_ov;
   // Values the held outputs must show outside the DONE edge
   logic [15:0] hold_q = '0, hold_r = '0;
   logic        hold_d0 = 1'b0, hold_ov = 1'b0;
   // Results seen at DONE
   logic [15:0] cap_q = '0, cap_r = '0;
   logic        cap_d0 = 1'b0, cap_ov = 1'b0;
   int          done_count = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
      end
   endtask

   function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] q, output logic [15:0] r,
                                 output logic d0, output logic ov);
      int ai, bi, qi, ri;
      ai = int'($signed(a));
      bi = int'($signed(b));
      if (bi == 0) begin
         q  = 16'hFFFF;
         r  = a;
         d0 = 1'b1;
         ov = 1'b0;
      end else begin
         qi = ai / bi;
         ri = ai % bi;
         q  = qi[15:0];
         r  = ri[15:0];
         d0 = 1'b0;
         ov = (ai == -32768) && (bi == -1);
      end
   endfunction

   // Per-cycle compare against the model
   always @(negedge clk) begin
      logic at_done;
      logic busy_exp;
      at_done  = pending && (cyc == k_edge + lat);
      busy_exp = pending && (cyc >= k_edge) && (cyc <= k_edge + lat);
      chk("DONE", DONE, at_done);
      chk("BUSY", BUSY, busy_exp);
      if (at_done) begin
         chk("Cociente@DONE", Cociente, exp_q);
         chk("Residuo@DONE", Residuo, exp_r);
         chk("DIV0@DONE", DIV0, exp_d0);
         chk("OVF@DONE", OVF, exp_ov);
         cap_q = Cociente; cap_r = Residuo; cap_d0 = DIV0; cap_ov = OVF;
         hold_q = exp_q; hold_r = exp_r; hold_d0 = exp_d0; hold_ov = exp_ov;
         done_count++;
         pending = 1'b0;
      end else begin
         chk("Cociente held", Cociente, hold_q);
         chk("Residuo held", Residuo, hold_r);
         chk("DIV0 held", DIV0, hold_d0);
         chk("OVF held", OVF, hold_ov);
      end
   end

   task automatic start_op(input logic [15:0] a, input logic [15:0] b);
      @(posedge clk); #1;
      Dividendo = a;
      Divisor   = b;
      init      = 1'b1;
      @(posedge clk); #1;
      init      = 1'b0;
      Dividendo = 16'($urandom);
      Divisor   = 16'($urandom);
      model(a, b, exp_q, exp_r, exp_d0, exp_ov);
      k_edge  = cyc;
      lat     = (b == 16'h0000) ? 2 : 18;
      hold_d0 = 1'b0;
      hold_ov = 1'b0;
      pending = 1'b1;
   endtask

   task automatic wait_done(input string name);
      int t;
      t = 0;
      while (pending && t < 60) begin
         @(posedge clk);
         t++;
      end
      if (pending) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s timeout: no DONE after %0d cycles", name, t);
         pending = 1'b0;
      end
   endtask

   task automatic check_lit(input string name, input logic [15:0] q, input logic [15:0] r,
                            input logic d0, input logic ov);
      chk({name, " quotient"}, cap_q, q);
      chk({name, " remainder"}, cap_r, r);
      chk({name, " DIV0"}, cap_d0, d0);
      chk({name, " OVF"}, cap_ov, ov);
      $display("op %-14s -> Cociente=%0d Residuo=%0d DIV0=%0b OVF=%0b", name,
               $signed(cap_q), $signed(cap_r), cap_d0, cap_ov);
   endtask

   typedef struct {
      string       name;
      logic [15:0] a, b, q, r;
      logic        d0, ov;
   } vec_t;

   vec_t vecs[11] = '{
      '{"100/7",        16'd100,   16'd7,     16'd14,    16'd2,     1'b0, 1'b0},
      '{"-100/7",       16'hFF9C,  16'd7,     16'hFFF2,  16'hFFFE,  1'b0, 1'b0},
      '{"100/-7",       16'd100,   16'hFFF9,  16'hFFF2,  16'd2,     1'b0, 1'b0},
      '{"-100/-7",      16'hFF9C,  16'hFFF9,  16'd14,    16'hFFFE,  1'b0, 1'b0},
      '{"MIN/-1",       16'h8000,  16'hFFFF,  16'h8000,  16'd0,     1'b0, 1'b1},
      '{"MIN/1",        16'h8000,  16'd1,     16'h8000,  16'd0,     1'b0, 1'b0},
      '{"1234/0",       16'd1234,  16'd0,     16'hFFFF,  16'd1234,  1'b1, 1'b0},
      '{"7/100",        16'd7,     16'd100,   16'd0,     16'd7,     1'b0, 1'b0},
      '{"-1/0",         16'hFFFF,  16'd0,     16'hFFFF,  16'hFFFF,  1'b1, 1'b0},
      '{"32767/MIN",    16'h7FFF,  16'h8000,  16'd0,     16'h7FFF,  1'b0, 1'b0},
      '{"MIN/MIN",      16'h8000,  16'h8000,  16'd1,     16'd0,     1'b0, 1'b0}
   };

   initial begin
      int dc;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);

      foreach (vecs[i]) begin
         start_op(vecs[i].a, vecs[i].b);
         wait_done(vecs[i].name);
         check_lit(vecs[i].name, vecs[i].q, vecs[i].r, vecs[i].d0, vecs[i].ov);
      end

      // Abort a running division with reset at iteration 8
      start_op(16'd30000, 16'd3);
      while (cyc < k_edge + 9) begin
         @(posedge clk); #1;
      end
      dc = done_count;
      reset   = 1'b0;
      pending = 1'b0;
      hold_q = '0; hold_r = '0; hold_d0 = 1'b0; hold_ov = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (25) @(posedge clk);
      chk("no DONE after abort", done_count, dc);
      $display("op %-14s -> aborted by reset, outputs cleared", "30000/3");
      start_op(16'd9, 16'd4);
      wait_done("9/4");
      check_lit("9/4", 16'd2, 16'd1, 1'b0, 1'b0);

      // init pulsed with new operands while busy must be ignored
      start_op(16'd500, 16'd9);
      while (cyc < k_edge + 5) begin
         @(posedge clk); #1;
      end
      init = 1'b1; Dividendo = 16'd1000; Divisor = 16'd3;
      @(posedge clk); #1;
      Dividendo = 16'd2000; Divisor = 16'd0;
      @(posedge clk); #1;
      init = 1'b0;
      wait_done("500/9");
      check_lit("500/9", 16'd55, 16'd5, 1'b0, 1'b0);

      repeat (4) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
